// File: rtl/spi_pkg.sv
// Shared types and command encodings for the SPI slave front end.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises MOSI frames into {cmd, payload} words for the RAM and
// serialises the RAM read reply onto MISO, MSB first.
module spi_slave
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int CNT_W = $clog2(ADDR_SIZE + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_TX   = CNT_W'(ADDR_SIZE);

    spi_state_e state, state_next;

    logic [CNT_W-1:0]     cnt;
    logic                 fwd;
    logic                 rd_addr_done;
    logic [ADDR_SIZE:0]   shift_in;
    logic [ADDR_SIZE-1:0] tx_shift;
    logic [1:0]           frame_cmd;

    assign frame_cmd = shift_in[ADDR_SIZE -: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (SS_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI)             state_next = WRITE;
                    else if (rd_addr_done) state_next = READ_DATA;
                    else                   state_next = READ_ADD;
                end
                default: state_next = state;
            endcase
        end
    end

    // cnt counts received bits until the frame is forwarded; afterwards CNT_LAST
    // means "awaiting reply" and CNT_TX..1 are the reply bits still to drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            fwd          <= 1'b0;
            rd_addr_done <= 1'b0;
            shift_in     <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || state == IDLE) begin
                cnt      <= '0;
                fwd      <= 1'b0;
                tx_shift <= '0;
            end else begin
                case (state)
                    CHK_CMD: begin
                        shift_in <= {shift_in[ADDR_SIZE-1:0], MOSI};
                        cnt      <= CNT_W'(1);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!fwd) begin
                            shift_in <= {shift_in[ADDR_SIZE-1:0], MOSI};
                            if (cnt == CNT_LAST) begin
                                rx_data  <= {shift_in, MOSI};
                                rx_valid <= 1'b1;
                                fwd      <= 1'b1;
                                if (frame_cmd == CMD_RD_ADDR) begin
                                    rd_addr_done <= 1'b1;
                                end else if (frame_cmd == CMD_RD_DATA) begin
                                    rd_addr_done <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (state == READ_DATA) begin
                            if (cnt == CNT_LAST) begin
                                if (tx_valid) begin
                                    tx_shift <= tx_data;
                                    cnt      <= CNT_TX;
                                end
                            end else if (cnt != '0) begin
                                tx_shift <= tx_shift << 1;
                                cnt      <= cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign MISO = (state == READ_DATA && fwd && cnt != '0 && cnt != CNT_LAST)
                  ? tx_shift[ADDR_SIZE-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: randomized frames and replies against a
// frame-level model of the read-address flag and expected MISO stream.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_flag = 1'b0;

    spi_slave #(.MEM_DEPTH(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // One full frame; reply_delay < 0 means no tx_valid is sent. cut = reply bits
    // observed before SS_n rises (or reset hits, when rst_mid is set).
    task automatic do_frame(input logic [9:0] frame, input int reply_delay,
                            input logic [7:0] reply, input int cut, input bit rst_mid);
        logic exp_rd;
        logic exp_bit;
        exp_rd = frame[9] && model_flag;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            n_checks++;
            if ({rx_valid, MISO} !== 2'b00) begin
                n_fail++;
                $display("FAIL frame_quiet: frame=%h bit=%0d got rx_valid=%b MISO=%b, required 0 0",
                         frame, i, rx_valid, MISO);
            end
            MOSI = frame[i];
        end
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_valid_pulse: frame=%h got %b, required 1", frame, rx_valid);
        end
        n_checks++;
        if (rx_data !== frame) begin
            n_fail++;
            $display("FAIL rx_data: got %h, required %h", rx_data, frame);
        end
        if (frame[9:8] == 2'b10) model_flag = 1'b1;
        else if (frame[9:8] == 2'b11) model_flag = 1'b0;
        MOSI = 1'($urandom);
        if (reply_delay >= 0) begin
            repeat (reply_delay) begin
                @(negedge clk);
                n_checks++;
                if ({rx_valid, MISO} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL reply_wait: got rx_valid=%b MISO=%b, required 0 0", rx_valid, MISO);
                end
                MOSI = 1'($urandom);
            end
            tx_data  = reply;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            for (int b = 0; b < cut; b++) begin
                exp_bit = exp_rd ? reply[7-b] : 1'b0;
                n_checks++;
                if (MISO !== exp_bit || rx_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miso_bit%0d: frame=%h reply=%h got MISO=%b rx_valid=%b, required %b 0",
                             b, frame, reply, MISO, rx_valid, exp_bit);
                end
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
                MOSI     = 1'($urandom);
                @(negedge clk);
                tx_valid = 1'b0;
            end
            if (cut >= 8) begin
                n_checks++;
                if (MISO !== 1'b0) begin
                    n_fail++;
                    $display("FAIL miso_after_reply: got %b, required 0", MISO);
                end
            end
        end else begin
            repeat (3) begin
                @(negedge clk);
                n_checks++;
                if ({rx_valid, MISO} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL post_frame_quiet: got rx_valid=%b MISO=%b, required 0 0", rx_valid, MISO);
                end
                MOSI = 1'($urandom);
            end
        end
        if (rst_mid) begin
            #2 rst_n = 1'b0;
            #1;
            model_flag = 1'b0;
            n_checks++;
            if ({MISO, rx_valid, rx_data} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_mid: got MISO=%b rx_valid=%b rx_data=%h, required 0 0 000",
                         MISO, rx_valid, rx_data);
            end
            SS_n = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            SS_n = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({MISO, rx_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL after_ss_high: got MISO=%b rx_valid=%b, required 0 0", MISO, rx_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        #12;
        n_checks++;
        if ({MISO, rx_valid, rx_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got MISO=%b rx_valid=%b rx_data=%h, required 0 0 000",
                     MISO, rx_valid, rx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_flag = 1'b0;
    endtask

    task automatic test_write();
        do_frame(10'h0A5, -1, 8'h00, 0, 1'b0);
        do_frame(10'h1F0, -1, 8'h00, 0, 1'b0);
        do_frame({1'b0, 9'($urandom)}, -1, 8'h00, 0, 1'b0);
    endtask

    task automatic test_read();
        do_frame(10'h207, -1, 8'h00, 0, 1'b0);
        do_frame({2'b11, 8'($urandom)}, 0, 8'hC3, 8, 1'b0);
        // flag now clear: a read-type frame takes the address path and never replies
        do_frame({2'b10, 8'($urandom)}, 1, 8'hFF, 8, 1'b0);
        do_frame({2'b11, 8'($urandom)}, 3, 8'($urandom), 8, 1'b0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        SS_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        SS_n = 1'b1;
        repeat (12) begin
            MOSI = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if ({rx_valid, MISO} !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_quiet: got rx_valid=%b MISO=%b, required 0 0", rx_valid, MISO);
            end
        end
        do_frame(10'h001, -1, 8'h00, 0, 1'b0);
        do_frame({2'b10, 8'($urandom)}, -1, 8'h00, 0, 1'b0);
        do_frame({2'b11, 8'($urandom)}, 0, 8'hA5, 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_frame({2'b10, 8'($urandom)}, -1, 8'h00, 0, 1'b0);
        do_frame({2'b11, 8'($urandom)}, 1, 8'h5A, 4, 1'b1);
        do_frame({2'b10, 8'($urandom)}, 0, 8'hFF, 8, 1'b0);
    endtask

    task automatic test_ignored_tx();
        @(negedge clk);
        SS_n = 1'b1; tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({rx_valid, MISO} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_tx_valid: got rx_valid=%b MISO=%b, required 0 0", rx_valid, MISO);
            end
        end
        do_frame({2'b01, 8'($urandom)}, 0, 8'hFF, 8, 1'b0);
        do_frame({2'b00, 8'($urandom)}, 2, 8'hAA, 8, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [9:0] f;
        int d;
        for (int n = 0; n < 24; n++) begin
            f = 10'($urandom);
            d = int'($urandom_range(0, 4)) - 1;
            do_frame(f, d, 8'($urandom), ($urandom_range(0, 3) == 0) ? 5 : 8, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid();
        test_ignored_tx();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
